// File: rtl/ball_draw_sequencer_if.sv
// Frame/render handshake bundle between the ball draw sequencer and its environment
// (rate divider, ball control, ball_render). The sequencer takes the slave view.
interface ball_draw_sequencer_if;
  logic       enable;
  logic       frameTick;
  logic       lhs_scored;
  logic       rhs_scored;
  logic       done_clearOld;
  logic       done_drawNew;
  logic       done_blackScreen;
  logic       clearOld_pulse;
  logic       drawNew_pulse;
  logic       blackScreen_pulse;
  logic       move_tick;
  logic       busy;
  logic [7:0] overrun_count;
  logic       timeout_err;

  modport master (
    output enable, frameTick, lhs_scored, rhs_scored,
    output done_clearOld, done_drawNew, done_blackScreen,
    input  clearOld_pulse, drawNew_pulse, blackScreen_pulse,
    input  move_tick, busy, overrun_count, timeout_err
  );

  modport slave (
    input  enable, frameTick, lhs_scored, rhs_scored,
    input  done_clearOld, done_drawNew, done_blackScreen,
    output clearOld_pulse, drawNew_pulse, blackScreen_pulse,
    output move_tick, busy, overrun_count, timeout_err
  );
endinterface

// File: rtl/ball_draw_sequencer.sv
// Per-frame render sequencer: clears the old ball, draws the new one, freezes after a
// score and blanks the screen, with overrun counting and a per-phase watchdog.
module ball_draw_sequencer #(
  parameter int SCORE_HOLD_FRAMES = 15,
  parameter int TIMEOUT_CYCLES    = 400000
) (
  input logic                  clk,
  input logic                  reset,
  ball_draw_sequencer_if.slave bus
);

  localparam int PW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int HW = (SCORE_HOLD_FRAMES > 0) ? $clog2(SCORE_HOLD_FRAMES + 1) : 1;
  localparam logic [PW-1:0] PHASE_LAST = PW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(SCORE_HOLD_FRAMES);

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_BLACK = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CLEAR = 3'd3;
  localparam logic [2:0] S_DRAW  = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [HW-1:0] hold_q, hold_d, hold_inc;
  logic [7:0]    over_q, over_d;
  logic          terr_q, terr_d;
  logic          move_q, move_d;
  logic          black_q, clear_q, draw_q, busy_q;
  logic          in_phase, phase_expired;

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    hold_d        = hold_q;
    over_d        = over_q;
    terr_d        = terr_q;
    move_d        = 1'b0;
    hold_inc      = hold_q + HW'(1);
    in_phase      = (state_q == S_BLACK) || (state_q == S_CLEAR) || (state_q == S_DRAW);
    phase_expired = (phase_q == PHASE_LAST);

    if (bus.enable) begin
      if (in_phase) begin
        phase_d = phase_q + PW'(1);
      end
      // A frame strobe landing in a render phase is lost; it is only counted.
      if (in_phase && bus.frameTick && (over_q != 8'hFF)) begin
        over_d = over_q + 8'd1;
      end

      case (state_q)
        S_INIT: begin
          state_d = S_BLACK;
          phase_d = '0;
        end
        S_BLACK: begin
          if (bus.done_blackScreen) begin
            state_d = S_WAIT;
          end else if (phase_expired) begin
            state_d = S_BLACK;
            phase_d = '0;
            terr_d  = 1'b1;
          end
        end
        S_WAIT: begin
          if (bus.frameTick) begin
            if (bus.lhs_scored || bus.rhs_scored) begin
              state_d = S_HOLD;
              hold_d  = '0;
            end else begin
              state_d = S_CLEAR;
              phase_d = '0;
            end
          end
        end
        S_CLEAR: begin
          if (bus.done_clearOld) begin
            state_d = S_DRAW;
            phase_d = '0;
          end else if (phase_expired) begin
            state_d = S_BLACK;
            phase_d = '0;
            terr_d  = 1'b1;
          end
        end
        S_DRAW: begin
          if (bus.done_drawNew) begin
            state_d = S_WAIT;
            move_d  = 1'b1;
          end else if (phase_expired) begin
            state_d = S_BLACK;
            phase_d = '0;
            terr_d  = 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.frameTick) begin
            hold_d = hold_inc;
            if (hold_inc == HOLD_LAST) begin
              state_d = S_BLACK;
              phase_d = '0;
            end
          end
        end
        default: state_d = S_INIT;
      endcase
    end
  end

  // Phase selects are registered from the next state so they never glitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
      phase_q <= '0;
      hold_q  <= '0;
      over_q  <= '0;
      terr_q  <= 1'b0;
      move_q  <= 1'b0;
      black_q <= 1'b0;
      clear_q <= 1'b0;
      draw_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      hold_q  <= hold_d;
      over_q  <= over_d;
      terr_q  <= terr_d;
      move_q  <= move_d;
      black_q <= (state_d == S_BLACK);
      clear_q <= (state_d == S_CLEAR);
      draw_q  <= (state_d == S_DRAW);
      busy_q  <= (state_d == S_BLACK) || (state_d == S_CLEAR) || (state_d == S_DRAW);
    end
  end

  assign bus.blackScreen_pulse = black_q;
  assign bus.clearOld_pulse    = clear_q;
  assign bus.drawNew_pulse     = draw_q;
  assign bus.busy              = busy_q;
  assign bus.move_tick         = move_q;
  assign bus.overrun_count     = over_q;
  assign bus.timeout_err       = terr_q;

endmodule

// File: doc/ball_draw_sequencer.md
BALL_DRAW_SEQUENCER -- requirements
Module: ball_draw_sequencer

Parameters
REQ-001 The block SHALL have parameter SCORE_HOLD_FRAMES, default 15: number of frameTicks the field freezes after a score before the screen clear.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 400000: maximum number of clocks spent in any render phase before the block aborts that phase.

Interface
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port enable, input, 1 bit: when 0, state, counters and outputs hold their values.
REQ-006 The block SHALL have port frameTick, input, 1 bit: one-cycle frame strobe from the rate divider.
REQ-007 The block SHALL have ports lhs_scored and rhs_scored, input, 1 bit each: score levels from ball control.
REQ-008 The block SHALL have ports done_clearOld, done_drawNew and done_blackScreen, input, 1 bit each: phase-complete flags from ball_render.
REQ-009 The block SHALL have ports clearOld_pulse, drawNew_pulse and blackScreen_pulse, output, 1 bit each: phase-select levels to ball_render.
REQ-010 The block SHALL have port move_tick, output, 1 bit: one-cycle strobe telling physics to advance the ball.
REQ-011 The block SHALL have port busy, output, 1 bit: high in any render phase.
REQ-012 The block SHALL have port overrun_count, output, 8 bits: count of dropped frameTicks, saturating at 255.
REQ-013 The block SHALL have port timeout_err, output, 1 bit: sticky flag set by a phase timeout.

Function
REQ-014 The block SHALL implement the states S_INIT, S_BLACK, S_WAIT, S_CLEAR, S_DRAW and S_HOLD.
REQ-015 All outputs SHALL be registered and decoded from the state register (Moore):
- S_BLACK: blackScreen_pulse=1
- S_CLEAR: clearOld_pulse=1
- S_DRAW: drawNew_pulse=1
- S_BLACK, S_CLEAR, S_DRAW: busy=1
- At most one phase-select output is high in any cycle.
REQ-016 S_INIT SHALL go to S_BLACK on the next enabled cycle.
REQ-017 S_BLACK SHALL go to S_WAIT on the cycle done_blackScreen=1.
REQ-018 In S_WAIT, a frameTick with lhs_scored=0 and rhs_scored=0 SHALL go to S_CLEAR.
REQ-019 In S_WAIT, a frameTick with lhs_scored=1 or rhs_scored=1 SHALL go to S_HOLD and clear the hold counter.
REQ-020 S_CLEAR SHALL go to S_DRAW when done_clearOld=1.
REQ-021 S_DRAW SHALL go to S_WAIT when done_drawNew=1, and move_tick SHALL be 1 for exactly the first cycle after that transition.
REQ-022 Latency from frameTick to clearOld_pulse high SHALL be 1 clock.
REQ-023 In S_HOLD, each frameTick SHALL increment the hold counter; on the frameTick where the count reaches SCORE_HOLD_FRAMES, the block SHALL go to S_BLACK.
REQ-024 A frameTick arriving in S_BLACK, S_CLEAR or S_DRAW SHALL be dropped and SHALL increment overrun_count, holding at 255.
REQ-025 A done input not matching the current phase SHALL be ignored.
REQ-026 If done_clearOld and frameTick coincide in S_CLEAR, the block SHALL take the done transition and count the overrun.
REQ-027 A phase cycle counter SHALL clear on entry to each render phase; reaching TIMEOUT_CYCLES-1 without done SHALL force S_BLACK, set timeout_err, and not assert move_tick.
REQ-028 A timeout occurring in S_BLACK SHALL restart S_BLACK with the counter cleared.
REQ-029 Counter widths SHALL be $clog2 of their maximum +1 bits; all comparisons SHALL be unsigned.
REQ-030 With enable=0, frameTick and done inputs SHALL be ignored and move_tick SHALL be 0.

Reset
REQ-031 On reset=1 at a clock edge, the block SHALL enter S_INIT and set all outputs to 0: phase selects, move_tick, busy, overrun_count=0, timeout_err=0.
REQ-032 On reset=1, the hold and phase counters SHALL clear.
REQ-033 Reset asserted mid-phase SHALL abort that phase in the same edge; blackScreen_pulse SHALL reassert 2 clocks after reset deasserts.

Verification
REQ-034 Power-up: reset 1 for 3 cycles, then release -> cycle 1 S_INIT with outputs 0, cycle 2 blackScreen_pulse=1; done_blackScreen -> next cycle all phase selects 0.
REQ-035 Normal frame: in S_WAIT, frameTick -> clearOld_pulse=1 next cycle; done_clearOld -> drawNew_pulse=1; done_drawNew -> move_tick=1 for exactly 1 cycle.
REQ-036 Overrun: 3 frameTicks during S_DRAW -> overrun_count=3; 300 ticks -> overrun_count=255.
REQ-037 Score: lhs_scored=1 at frameTick -> S_HOLD; after 15 further frameTicks -> blackScreen_pulse=1; no move_tick throughout.
REQ-038 Timeout: TIMEOUT_CYCLES=16, no done_clearOld -> after 16 cycles blackScreen_pulse=1, timeout_err=1, and timeout_err stays 1 after recovery.
REQ-039 Mid-phase reset: reset during S_DRAW -> drawNew_pulse=0 the next cycle and overrun_count=0.
